// File: rtl/rle_block_sequencer.sv
// rle_block_sequencer: row-level controller for the 8x8 run-length encoder.
// It takes one 64-bit zig-zag row per handshake and scans it one coefficient
// per cycle. It emits {run,level} symbols, adds EOB after the last row of a
// block, packs 8 symbols per 128-bit word and writes the words to SRAM.
// Optional build macro: RLE_BLK_ALIGN_EN. When it is defined, every block
// starts on a fresh SRAM word: a partial word left after EOB is auto-flushed.
//
// state | meaning
// IDLE  | waiting for a row or a flush request; in_ready = ~flush
// SCAN  | 8 cycles, one coefficient per cycle, MSB byte first
// EOB   | emit end-of-block symbol, clear run and row counters
// FLUSH | write the partial word (unused slots zero), restart at slot 0
module rle_block_sequencer #(
  parameter int          ADDR_W  = 14,
  parameter int          ROWS    = 8,
  parameter logic [15:0] EOB_SYM = 16'hFF7F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_data,
  input  logic              flush,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  output logic              blk_done,
  output logic              busy
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EOB, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [63:0]        row_buf;
  logic [2:0]         col;
  logic [ROW_W-1:0]   row;
  logic [7:0]         run;
  logic [2:0]         slot;
  logic [127:0]       word, word_ins;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         coeff;
  logic               accept, sym_vld;
  logic [15:0]        sym;

  // The row buffer shifts left each SCAN cycle, so the current coefficient is always the top byte.
  assign coeff = row_buf[63:56];
  assign busy  = (state != IDLE) | mem_we;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, handshake and symbol generation.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    sym_vld   = 1'b0;
    sym       = 16'h0000;
    case (state)
      IDLE: begin
        in_ready = ~flush;
        if (flush) begin
          if (slot != 3'd0) state_nxt = FLUSH;
        end else if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (coeff != 8'h00) begin
          sym_vld = 1'b1;
          sym     = {run, coeff};
        end
        if (col == 3'd7) state_nxt = (row == LAST_ROW) ? EOB : IDLE;
      end
      EOB: begin
        sym_vld = 1'b1;
        sym     = EOB_SYM;
`ifdef RLE_BLK_ALIGN_EN
        // EOB into slot 7 completes the word, so nothing is left to flush.
        state_nxt = (slot != 3'd7) ? FLUSH : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: row buffer, column/row counters and the zero-run counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_buf <= '0;
      col     <= '0;
      row     <= '0;
      run     <= '0;
    end else begin
      if (accept) begin
        row_buf <= in_data;
        col     <= '0;
      end else if (state == SCAN) begin
        row_buf <= row_buf << 8;
        col     <= col + 3'd1;
        if (coeff != 8'h00)   run <= '0;
        else if (run != 8'd63) run <= run + 8'd1;
        if (col == 3'd7 && row != LAST_ROW) row <= row + ROW_W'(1);
      end else if (state == EOB) begin
        // Trailing zeros of a block carry no information and are dropped.
        run <= '0;
        row <= '0;
      end
    end
  end

  // Insert the current symbol into its slot; slot 0 is the most significant halfword.
  always_comb begin
    word_ins = word;
    for (int i = 0; i < 8; i++) begin
      if (slot == 3'(i)) word_ins[127-16*i -: 16] = sym;
    end
  end

  // Packer and SRAM write port. A full word is written on the edge that fills slot 7, so
  // the next symbol lands in slot 0 of the cleared word without a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word      <= '0;
      slot      <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      blk_done  <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      blk_done <= (state == EOB);
      if (state == FLUSH) begin
        mem_we    <= 1'b1;
        mem_wdata <= word;
        mem_addr  <= addr;
        addr      <= addr + ADDR_W'(1);
        word      <= '0;
        slot      <= '0;
      end else if (sym_vld) begin
        if (slot == 3'd7) begin
          mem_we    <= 1'b1;
          mem_wdata <= word_ins;
          mem_addr  <= addr;
          addr      <= addr + ADDR_W'(1);
          word      <= '0;
          slot      <= '0;
        end else begin
          word <= word_ins;
          slot <= slot + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_block_sequencer.sv
// Scoreboard bench for rle_block_sequencer, built with a 3-bit address so that wrap is reached quickly.
module tb_rle_block_sequencer;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          flush = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_wdata;
  logic          blk_done;
  logic          busy;

  rle_block_sequencer #(.ADDR_W(AW), .ROWS(8), .EOB_SYM(16'hFF7F)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .blk_done(blk_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int blk_cnt = 0;
  logic blk_prev = 1'b0;
  logic [AW-1:0] q_addr[$];
  logic [127:0]  q_data[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: every write must match the oldest expected write; blk_done pulses are counted.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        if (q_addr.size() == 0) begin
          total++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", mem_addr, mem_wdata);
        end else begin
          logic [AW-1:0] ea;
          logic [127:0]  ed;
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          check("write_addr", 128'(mem_addr), 128'(ea));
          check("write_data", mem_wdata, ed);
        end
      end
      if (blk_done) begin
        blk_cnt++;
        if (blk_prev) begin
          total++;
          $display("FAIL blk_done_width: got 2+ cycles expected 1");
        end
      end
      blk_prev <= blk_done;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("ready_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("idle_timeout");
  endtask

  task automatic send_row(input logic [63:0] d);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    wait_idle();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [127:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  // Closes the partial word of a finished block: automatic in the aligned build, by flush otherwise.
  task automatic end_block(input logic [AW-1:0] a, input logic [127:0] d);
    expect_write(a, d);
    wait_idle();
`ifndef RLE_BLK_ALIGN_EN
    flush_pulse();
`endif
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mem_we",    128'(mem_we),    128'(0));
    check("rst_mem_addr",  128'(mem_addr),  128'(0));
    check("rst_mem_wdata", mem_wdata,       128'(0));
    check("rst_blk_done",  128'(blk_done),  128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    reset = 1'b1;

    // Reset mid-SCAN of row 3; the following block proves row/run were cleared.
    for (int r = 0; r < 4; r++) send_row(64'h0);
    repeat (3) @(negedge clk);
    check("mid_busy_before_reset", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_mem_we",    128'(mem_we),    128'(0));
    check("mid_rst_mem_addr",  128'(mem_addr),  128'(0));
    check("mid_rst_mem_wdata", mem_wdata,       128'(0));
    check("mid_rst_blk_done",  128'(blk_done),  128'(0));
    check("mid_rst_busy",      128'(busy),      128'(0));
    check("mid_rst_in_ready",  128'(in_ready),  128'(1));
    @(negedge clk);
    reset = 1'b1;

    // Single coefficient at row0/col0.
    send_row(64'h0500_0000_0000_0000);
    for (int r = 1; r < 8; r++) send_row(64'h0);
    end_block(3'd0, 128'h0005_FF7F_0000_0000_0000_0000_0000_0000);

    // Run continues across the row boundary: 7 + 2 zeros before 8'h09.
    send_row(64'h0100_0000_0000_0000);
    send_row(64'h0000_0900_0000_0000);
    for (int r = 2; r < 8; r++) send_row(64'h0);
    end_block(3'd1, 128'h0001_0909_FF7F_0000_0000_0000_0000_0000);

    // All-nonzero block: 8 full words at addr 2..7,0,1 (wraps), EOB in slot 0 of the next word.
    for (int w = 0; w < 8; w++) expect_write(3'(w + 2), {8{16'h0011}});
    for (int r = 0; r < 8; r++) send_row({8{8'h11}});
    end_block(3'd2, 128'hFF7F_0000_0000_0000_0000_0000_0000_0000);

    // Longest possible run inside one block: 63 zeros before the last coefficient.
    for (int r = 0; r < 7; r++) send_row(64'h0);
    send_row(64'h0000_0000_0000_0022);
    end_block(3'd3, 128'h3F22_FF7F_0000_0000_0000_0000_0000_0000);

    // Flush with an empty word does nothing.
    flush_pulse();
    wait_idle();

    // Flush beats in_valid in IDLE: in_ready drops and the row is not taken.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {8{8'h77}};
    #1;
    check("flush_blocks_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept_busy", 128'(busy), 128'(0));

    repeat (20) @(negedge clk);
    check("pending_writes", 128'(q_addr.size()), 128'(0));
    check("blk_done_count", 128'(blk_cnt), 128'(4));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
